serial_csel_subtractor: RTL

//   Multi-cycle unsigned/two's-complement subtractor: {bout,diff} = a - b - bin.

---
 rtl/sub_pkg.sv | 18 +
 rtl/csel_sub_chunk.sv | 37 +++
 rtl/serial_csel_subtractor.sv | 120 ++++++++++++
 3 files changed

// File: rtl/sub_pkg.sv
// Shared definitions for the serial carry-select subtractor: FSM encoding,
// default chunk width and the chunk-index width helper.
package sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int CHUNK_DEF = 4;

  // A single-chunk configuration still needs a 1-bit index register.
  function automatic int idx_width(input int nchunk);
    return (nchunk > 1) ? $clog2(nchunk) : 1;
  endfunction

endpackage

// File: rtl/csel_sub_chunk.sv
// Combinational CHUNK-bit carry-select subtract stage: d = a - b - bsel, bo = borrow out.
// Both borrow-in candidates ripple in parallel; bsel only drives the final mux.
module csel_sub_chunk #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             bsel,
  output logic [CHUNK-1:0] d,
  output logic             bo
);

  logic [CHUNK-1:0] nb;
  logic [CHUNK-1:0] s0, s1;
  logic [CHUNK:0]   c0, c1;

  // Subtraction as a + ~b + ~borrow_in: borrow_in=0 means carry-in 1.
  always_comb begin
    nb    = ~b;
    s0    = '0;
    s1    = '0;
    c0    = '0;
    c1    = '0;
    c0[0] = 1'b1;
    c1[0] = 1'b0;
    for (int i = 0; i < CHUNK; i++) begin
      s0[i]   = a[i] ^ nb[i] ^ c0[i];
      c0[i+1] = (a[i] & nb[i]) | (c0[i] & (a[i] ^ nb[i]));
      s1[i]   = a[i] ^ nb[i] ^ c1[i];
      c1[i+1] = (a[i] & nb[i]) | (c1[i] & (a[i] ^ nb[i]));
    end
  end

  assign d  = bsel ? s1 : s0;
  assign bo = bsel ? ~c1[CHUNK] : ~c0[CHUNK];

endmodule

// File: rtl/serial_csel_subtractor.sv
// Multi-cycle {bout,diff} = a - b - bin, CHUNK bits per cycle LSB first; result after WIDTH/CHUNK
// RUN cycles, held under out_ready backpressure. SUB_OVF_FLAG_EN adds the signed-overflow flag ovf.
module serial_csel_subtractor
  import sub_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = CHUNK_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             zero
`ifdef SUB_OVF_FLAG_EN
  ,
  output logic             ovf
`endif
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IW     = idx_width(NCHUNK);
  localparam logic [IW-1:0] LAST = IW'(NCHUNK - 1);

  if ((CHUNK < 1) || (WIDTH % CHUNK != 0)) begin : g_bad_cfg
    $error("serial_csel_subtractor: WIDTH must be a positive multiple of CHUNK");
  end

  state_t           state;
  logic [WIDTH-1:0] a_q, b_q, acc, acc_nxt;
  logic             borrow;
  logic [IW-1:0]    idx;
  logic [CHUNK-1:0] a_c, b_c, d_c;
  logic             bo_c;

  assign a_c = a_q[idx*CHUNK +: CHUNK];
  assign b_c = b_q[idx*CHUNK +: CHUNK];

  csel_sub_chunk #(.CHUNK(CHUNK)) u_chunk (
    .a    (a_c),
    .b    (b_c),
    .bsel (borrow),
    .d    (d_c),
    .bo   (bo_c)
  );

  // Accumulator with the current chunk merged in, so DONE flags see the final value.
  always_comb begin
    acc_nxt = acc;
    acc_nxt[idx*CHUNK +: CHUNK] = d_c;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      acc       <= '0;
      borrow    <= 1'b0;
      idx       <= '0;
      diff      <= '0;
      bout      <= 1'b0;
      zero      <= 1'b0;
`ifdef SUB_OVF_FLAG_EN
      ovf       <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q      <= a;
            b_q      <= b;
            borrow   <= bin;
            idx      <= '0;
            acc      <= '0;
            in_ready <= 1'b0;
            state    <= RUN;
          end
        end
        RUN: begin
          acc    <= acc_nxt;
          borrow <= bo_c;
          idx    <= idx + 1'b1;
          if (idx == LAST) begin
            idx       <= '0;
            diff      <= acc_nxt;
            bout      <= bo_c;
            zero      <= (acc_nxt == '0);
`ifdef SUB_OVF_FLAG_EN
            ovf       <= (a_q[WIDTH-1] != b_q[WIDTH-1]) && (acc_nxt[WIDTH-1] != a_q[WIDTH-1]);
`endif
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule
